// File: rtl/npu.sv
// npu: small vector/matrix processor. Each instruction walks FETCH -> LATCH ->
// EXEC -> WB. It holds three 16-entry vector register files and a 16-tile matrix
// register file. END_CHAIN parks the core in HALT until the next reset.
module npu #(
    parameter int  PREC             = 8,
    parameter int  LANES            = 4,
    parameter int  DRAM_AWIDTH      = 10,
    parameter int  INSTR_MEM_AWIDTH = 8,
    localparam int DRAM_DWIDTH      = LANES * PREC,
    localparam int INSTR_WIDTH      = 4 + 3 + DRAM_AWIDTH + DRAM_AWIDTH + 3 + DRAM_AWIDTH
) (
    input  logic                        clk,
    input  logic                        reset_npu,
    input  logic [INSTR_WIDTH-1:0]      instruction,
    output logic                        get_instr,
    output logic [INSTR_MEM_AWIDTH-1:0] get_instr_addr,
    input  logic [DRAM_DWIDTH-1:0]      input_data_DRAM,
    output logic [DRAM_DWIDTH-1:0]      output_data_DRAM,
    output logic [DRAM_AWIDTH-1:0]      dram_addr,
    output logic                        dram_write_enable
);
    localparam int AW = DRAM_AWIDTH;

    localparam logic [3:0] OP_VRD   = 4'd1;
    localparam logic [3:0] OP_VWR   = 4'd2;
    localparam logic [3:0] OP_MRD   = 4'd3;
    localparam logic [3:0] OP_MVMUL = 4'd4;
    localparam logic [3:0] OP_VVADD = 4'd5;
    localparam logic [3:0] OP_END   = 4'd7;

    typedef enum logic [2:0] {S_FETCH, S_LATCH, S_EXEC, S_WB, S_HALT} state_e;

    state_e                      state_q;
    logic [INSTR_MEM_AWIDTH-1:0] pc_q;
    logic [INSTR_WIDTH-1:0]      ir_q;

    // Register files are deliberately left out of reset.
    logic [DRAM_DWIDTH-1:0] vrf_q [3][16];
    logic [DRAM_DWIDTH-1:0] mrf_q [16][LANES];

    // Instruction fields.
    logic [3:0]    opcode;
    logic [2:0]    src_id;
    logic [2:0]    dstn_id;
    logic [AW-1:0] op1_addr;
    logic [AW-1:0] op2_addr;
    logic [AW-1:0] dstn_addr;

    assign opcode    = ir_q[3*AW+9 -: 4];
    assign src_id    = ir_q[3*AW+5 -: 3];
    assign op1_addr  = ir_q[3*AW+2 -: AW];
    assign op2_addr  = ir_q[2*AW+2 -: AW];
    assign dstn_id   = ir_q[AW+2 -: 3];
    assign dstn_addr = ir_q[AW-1:0];

    // Only the low four bits of op1 select a register or a tile.
    logic unused_op1;
    assign unused_op1 = ^op1_addr[AW-1:4];

    // Every strobe is gated by reset so that it drops the moment reset rises.
    logic in_exec;
    logic in_wb;
    assign in_exec = (state_q == S_EXEC) && !reset_npu;
    assign in_wb   = (state_q == S_WB)   && !reset_npu;

    // Sequencer: fetch, latch, execute, write back, then advance the PC.
    always_ff @(posedge clk or posedge reset_npu) begin
        if (reset_npu) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            case (state_q)
                S_FETCH: state_q <= S_LATCH;
                S_LATCH: begin
                    ir_q    <= instruction;
                    state_q <= S_EXEC;
                end
                S_EXEC:  state_q <= (opcode == OP_END) ? S_HALT : S_WB;
                S_WB: begin
                    pc_q    <= pc_q + 1'b1;
                    state_q <= S_FETCH;
                end
                S_HALT:  state_q <= S_HALT;
                default: state_q <= S_FETCH;
            endcase
        end
    end

    assign get_instr      = (state_q == S_FETCH) && !reset_npu;
    assign get_instr_addr = get_instr ? pc_q : '0;

    // Register-file read ports. A vector id above 2 reads as zero.
    logic [DRAM_DWIDTH-1:0] rd_a;
    logic [DRAM_DWIDTH-1:0] rd_b;
    logic [DRAM_DWIDTH-1:0] vec0;

    // Read operand A, operand B, and the VRF0 vector used by MV_MUL.
    always_comb begin
        rd_a = '0;
        rd_b = '0;
        if (src_id <= 3'd2) begin
            rd_a = vrf_q[src_id[1:0]][op1_addr[3:0]];
            rd_b = vrf_q[src_id[1:0]][op2_addr[3:0]];
        end
        vec0 = vrf_q[0][op2_addr[3:0]];
    end

    // Matrix-vector product. Each lane keeps only the low PREC bits of its signed dot product.
    logic [DRAM_DWIDTH-1:0]   mv_res;
    logic [PREC-1:0]          acc;
    logic signed [PREC-1:0]   ea;
    logic signed [PREC-1:0]   eb;
    logic signed [2*PREC-1:0] prod;

    always_comb begin
        mv_res = '0;
        acc    = '0;
        ea     = '0;
        eb     = '0;
        prod   = '0;
        for (int i = 0; i < LANES; i++) begin
            acc = '0;
            for (int j = 0; j < LANES; j++) begin
                ea   = mrf_q[op1_addr[3:0]][i][j*PREC +: PREC];
                eb   = vec0[j*PREC +: PREC];
                prod = (2*PREC)'(ea) * (2*PREC)'(eb);
                acc  = acc + prod[PREC-1:0];
            end
            mv_res[i*PREC +: PREC] = acc;
        end
    end

    // Lane-wise add. Each lane wraps independently modulo 2^PREC.
    logic [DRAM_DWIDTH-1:0] add_res;

    always_comb begin
        add_res = '0;
        for (int i = 0; i < LANES; i++)
            add_res[i*PREC +: PREC] = rd_a[i*PREC +: PREC] + rd_b[i*PREC +: PREC];
    end

    // VRF write port. The ALU results land in EXEC and DRAM loads land in WB.
    logic                   vwr_en;
    logic [1:0]             vwr_id;
    logic [3:0]             vwr_addr;
    logic [DRAM_DWIDTH-1:0] vwr_data;
    logic                   mwr_en;

    always_comb begin
        vwr_en   = 1'b0;
        vwr_id   = dstn_id[1:0];
        vwr_addr = dstn_addr[3:0];
        vwr_data = '0;
        mwr_en   = 1'b0;
        if (in_exec && opcode == OP_MVMUL) begin
            vwr_en   = (dstn_id <= 3'd2);
            vwr_data = mv_res;
        end else if (in_exec && opcode == OP_VVADD) begin
            vwr_en   = (dstn_id <= 3'd2);
            vwr_data = add_res;
        end else if (in_wb && opcode == OP_VRD) begin
            vwr_en   = (src_id <= 3'd2);
            vwr_id   = src_id[1:0];
            vwr_addr = op1_addr[3:0];
            vwr_data = input_data_DRAM;
        end
        if (in_wb && opcode == OP_MRD)
            mwr_en = (int'(src_id[1:0]) < LANES);
    end

    // Register-file storage. It has no reset, so its contents survive a reset.
    always_ff @(posedge clk) begin
        if (vwr_en)
            vrf_q[vwr_id][vwr_addr] <= vwr_data;
        if (mwr_en)
            mrf_q[op1_addr[3:0]][src_id[1:0]] <= input_data_DRAM;
    end

    // DRAM side. These outputs are driven only during EXEC and are zero in every other state.
    always_comb begin
        dram_addr         = '0;
        output_data_DRAM  = '0;
        dram_write_enable = 1'b0;
        if (in_exec) begin
            if (opcode == OP_VRD || opcode == OP_MRD) begin
                dram_addr = op2_addr;
            end else if (opcode == OP_VWR) begin
                dram_addr         = dstn_addr;
                output_data_DRAM  = rd_a;
                dram_write_enable = 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_npu.sv
// tb_npu: bench for npu. It provides instruction memory and DRAM models. Directed
// programs cover the example scenarios. A random program is checked against an
// instruction-level interpreter.
module tb_npu;
    localparam int PREC = 8;
    localparam int LANES = 4;
    localparam int AW = 10;
    localparam int IAW = 8;
    localparam int DW = 32;
    localparam int IW = 40;

    localparam int NOP = 0, VRD = 1, VWR = 2, MRD = 3, MVMUL = 4, VVADD = 5, ENDC = 7;

    logic           clk;
    logic           reset_npu;
    logic [IW-1:0]  instruction;
    logic           get_instr;
    logic [IAW-1:0] get_instr_addr;
    logic [DW-1:0]  input_data_DRAM;
    logic [DW-1:0]  output_data_DRAM;
    logic [AW-1:0]  dram_addr;
    logic           dram_write_enable;

    npu #(.PREC(PREC), .LANES(LANES), .DRAM_AWIDTH(AW), .INSTR_MEM_AWIDTH(IAW)) dut (
        .clk(clk), .reset_npu(reset_npu), .instruction(instruction),
        .get_instr(get_instr), .get_instr_addr(get_instr_addr),
        .input_data_DRAM(input_data_DRAM), .output_data_DRAM(output_data_DRAM),
        .dram_addr(dram_addr), .dram_write_enable(dram_write_enable)
    );

    logic [IW-1:0] imem [256];
    logic [DW-1:0] dram [1024];

    int          cycle = 0;
    int          we_run = 0;
    int          fq_cyc[$];
    int          fq_addr[$];
    int          runq[$];
    int          nz_q[$];
    logic [41:0] wlog[$];
    bit          mon_en = 0;

    int checks = 0;
    int errors = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Memories respond one cycle after the address. Fetches and writes are logged.
    always @(posedge clk) begin
        if (get_instr) begin
            instruction <= imem[get_instr_addr];
            fq_cyc.push_back(cycle);
            fq_addr.push_back(int'(get_instr_addr));
        end
        input_data_DRAM <= dram[dram_addr];
        if (dram_write_enable) begin
            dram[dram_addr] <= output_data_DRAM;
            wlog.push_back({dram_addr, output_data_DRAM});
            we_run <= we_run + 1;
        end else begin
            if (we_run != 0) runq.push_back(we_run);
            we_run <= 0;
        end
        cycle <= cycle + 1;
    end

    // Watch for DRAM activity where none should occur.
    always @(negedge clk) begin
        if (mon_en && (dram_write_enable || dram_addr != 0 || output_data_DRAM != 0))
            nz_q.push_back(cycle);
    end

    function automatic logic [IW-1:0] enc(input int op, input int src, input int a1,
                                          input int a2, input int did, input int da);
        return {op[3:0], src[2:0], a1[9:0], a2[9:0], did[2:0], da[9:0]};
    endfunction

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) imem[i] <= '0;
    endtask

    task automatic do_reset();
        reset_npu = 1;
        fq_cyc.delete(); fq_addr.delete(); runq.delete(); nz_q.delete(); wlog.delete();
        repeat (2) @(negedge clk);
        reset_npu = 0;
    endtask

    task automatic run_halt(input int budget, input string name);
        bit done;
        done = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (fq_cyc.size() > 0 && cycle - fq_cyc[fq_cyc.size()-1] > 12) begin
                done = 1;
                break;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_halt: still fetching after %0d cycles, required halt", name, budget);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DW-1:0] m_vrf [3][16];
    logic [DW-1:0] m_mrf [16][4];
    logic [DW-1:0] m_dram [1024];
    logic [41:0]   exp_q[$];

    function automatic logic [DW-1:0] m_rdv(input int id, input int a);
        if (id > 2) return '0;
        return m_vrf[id][a];
    endfunction

    function automatic int sl(input logic [DW-1:0] w, input int i);
        logic [7:0] b;
        b = w[i*8 +: 8];
        return int'($signed(b));
    endfunction

    task automatic model_exec(input logic [IW-1:0] ins, output bit halt);
        int op, src, a1, a2, did, da, acc;
        logic [DW-1:0] v, res;
        op  = int'(ins[39:36]); src = int'(ins[35:33]);
        a1  = int'(ins[32:23]); a2  = int'(ins[22:13]);
        did = int'(ins[12:10]); da  = int'(ins[9:0]);
        halt = 0;
        res = '0;
        case (op)
            VRD: if (src <= 2) m_vrf[src][a1 % 16] = m_dram[a2];
            VWR: begin
                v = m_rdv(src, a1 % 16);
                m_dram[da] = v;
                exp_q.push_back({da[9:0], v});
            end
            MRD: m_mrf[a1 % 16][src % 4] = m_dram[a2];
            MVMUL: begin
                v = m_vrf[0][a2 % 16];
                for (int i = 0; i < 4; i++) begin
                    acc = 0;
                    for (int j = 0; j < 4; j++) acc += sl(m_mrf[a1 % 16][i], j) * sl(v, j);
                    res[i*8 +: 8] = acc[7:0];
                end
                if (did <= 2) m_vrf[did][da % 16] = res;
            end
            VVADD: begin
                for (int i = 0; i < 4; i++)
                    res[i*8 +: 8] = 8'((sl(m_rdv(src, a1 % 16), i) + sl(m_rdv(src, a2 % 16), i)) & 255);
                if (did <= 2) m_vrf[did][da % 16] = res;
            end
            ENDC: halt = 1;
            default: ;
        endcase
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_npu = 1;
        clear_imem();
        repeat (3) @(negedge clk);
        checks++;
        if (get_instr !== 1'b0 || get_instr_addr !== '0) begin
            errors++;
            $display("FAIL reset_fetch: get_instr=%b addr=%0d, required 0/0", get_instr, get_instr_addr);
        end
        checks++;
        if (dram_write_enable !== 1'b0 || dram_addr !== '0 || output_data_DRAM !== '0) begin
            errors++;
            $display("FAIL reset_dram: we=%b addr=%0d data=%h, required all 0",
                     dram_write_enable, dram_addr, output_data_DRAM);
        end
        reset_npu = 0;
        #1;
        checks++;
        if (get_instr !== 1'b1 || get_instr_addr !== '0) begin
            errors++;
            $display("FAIL reset_release: get_instr=%b addr=%0d, required 1/0", get_instr, get_instr_addr);
        end
    endtask

    task automatic test_fetch_wrap();
        bit ok;
        clear_imem();
        mon_en = 1;
        do_reset();
        ok = 0;
        for (int k = 0; k < 1200; k++) begin
            @(negedge clk);
            if (fq_cyc.size() >= 258) begin ok = 1; break; end
        end
        mon_en = 0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL fetch_count: got %0d fetches, required 258", fq_cyc.size());
        end else begin
            for (int k = 1; k < 8; k++) begin
                checks++;
                if (fq_cyc[k] - fq_cyc[k-1] !== 4 || fq_addr[k] !== k) begin
                    errors++;
                    $display("FAIL fetch_cadence[%0d]: gap=%0d addr=%0d, required gap 4 addr %0d",
                             k, fq_cyc[k] - fq_cyc[k-1], fq_addr[k], k);
                end
            end
            checks++;
            if (fq_addr[0] !== 0 || fq_addr[255] !== 255 || fq_addr[256] !== 0) begin
                errors++;
                $display("FAIL pc_wrap: addr0=%0d addr255=%0d addr256=%0d, required 0/255/0",
                         fq_addr[0], fq_addr[255], fq_addr[256]);
            end
        end
        checks++;
        if (nz_q.size() !== 0) begin
            errors++;
            $display("FAIL nop_dram_idle: %0d active cycles, required 0", nz_q.size());
        end
    endtask

    task automatic test_vrd_vwr();
        clear_imem();
        dram[5] <= 32'h04030201;
        dram[9] <= 32'h0;
        imem[0] <= enc(VRD, 0, 3, 5, 0, 0);
        imem[1] <= enc(VWR, 0, 3, 0, 0, 9);
        imem[2] <= enc(ENDC, 0, 0, 0, 0, 0);
        do_reset();
        run_halt(200, "vrd_vwr");
        checks++;
        if (wlog.size() !== 1 || wlog[0] !== {10'd9, 32'h04030201}) begin
            errors++;
            $display("FAIL vwr_write: n=%0d first=%h, required 1 write %h",
                     wlog.size(), (wlog.size() > 0) ? wlog[0] : 42'h0, {10'd9, 32'h04030201});
        end
        checks++;
        if (runq.size() !== 1 || runq[0] !== 1) begin
            errors++;
            $display("FAIL vwr_pulse: pulses=%0d len=%0d, required 1 pulse of 1 cycle",
                     runq.size(), (runq.size() > 0) ? runq[0] : 0);
        end
        checks++;
        if (dram[9] !== 32'h04030201) begin
            errors++;
            $display("FAIL vwr_dram: got %h, required 04030201", dram[9]);
        end
    endtask

    task automatic test_mvmul();
        clear_imem();
        for (int r = 0; r < 4; r++) begin
            dram[100 + r] <= 32'h01010101;
            imem[r] <= enc(MRD, r, 2, 100 + r, 0, 0);
        end
        dram[104] <= 32'h04030201;
        dram[200] <= 32'h0;
        imem[4] <= enc(VRD, 0, 0, 104, 0, 0);
        imem[5] <= enc(MVMUL, 0, 2, 0, 1, 0);
        imem[6] <= enc(VWR, 1, 0, 0, 0, 200);
        imem[7] <= enc(ENDC, 0, 0, 0, 0, 0);
        do_reset();
        run_halt(300, "mvmul");
        checks++;
        if (dram[200] !== 32'h0A0A0A0A) begin
            errors++;
            $display("FAIL mvmul_result: got %h, required 0a0a0a0a", dram[200]);
        end
    endtask

    task automatic test_vvadd();
        clear_imem();
        dram[110] <= 32'h7F7F0102;
        dram[111] <= 32'h01020304;
        dram[203] <= 32'hFFFFFFFF;
        imem[0] <= enc(VRD, 2, 0, 110, 0, 0);
        imem[1] <= enc(VRD, 2, 1, 111, 0, 0);
        imem[2] <= enc(VVADD, 2, 0, 1, 1, 4);
        imem[3] <= enc(VWR, 1, 4, 0, 0, 201);
        imem[4] <= enc(VVADD, 2, 0, 1, 2, 0);   // overwrites one of its own sources
        imem[5] <= enc(VWR, 2, 0, 0, 0, 202);
        imem[6] <= enc(VWR, 2, 1, 0, 0, 204);
        imem[7] <= enc(VWR, 3, 0, 0, 0, 203);   // id 3 reads as zero
        imem[8] <= enc(ENDC, 0, 0, 0, 0, 0);
        do_reset();
        run_halt(300, "vvadd");
        checks++;
        if (dram[201] !== 32'h80810406) begin
            errors++;
            $display("FAIL vvadd_wrap: got %h, required 80810406", dram[201]);
        end
        checks++;
        if (dram[202] !== 32'h80810406 || dram[204] !== 32'h01020304) begin
            errors++;
            $display("FAIL vvadd_self: got %h/%h, required 80810406/01020304", dram[202], dram[204]);
        end
        checks++;
        if (dram[203] !== 32'h0) begin
            errors++;
            $display("FAIL bad_id_read: got %h, required 00000000", dram[203]);
        end
    endtask

    task automatic test_halt();
        clear_imem();
        imem[3] <= enc(ENDC, 0, 0, 0, 0, 0);
        do_reset();
        repeat (130) @(negedge clk);
        checks++;
        if (fq_cyc.size() !== 4 || fq_addr[fq_addr.size()-1] !== 3) begin
            errors++;
            $display("FAIL halt_fetches: n=%0d last=%0d, required 4 ending at 3",
                     fq_cyc.size(), (fq_addr.size() > 0) ? fq_addr[fq_addr.size()-1] : -1);
        end
        reset_npu = 1;
        @(negedge clk);
        reset_npu = 0;
        #1;
        checks++;
        if (get_instr !== 1'b1 || get_instr_addr !== '0) begin
            errors++;
            $display("FAIL halt_restart: get_instr=%b addr=%0d, required 1/0", get_instr, get_instr_addr);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        clear_imem();
        dram[5]  <= 32'h04030201;
        dram[20] <= 32'hDEADBEEF;
        imem[0] <= enc(VRD, 0, 3, 5, 0, 0);
        imem[1] <= enc(VWR, 0, 3, 0, 0, 20);
        imem[2] <= enc(ENDC, 0, 0, 0, 0, 0);
        do_reset();
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (dram_write_enable) begin seen = 1; break; end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL midreset_reach: write strobe never seen, required within 40 cycles");
        end
        reset_npu = 1;
        #1;
        checks++;
        if (dram_write_enable !== 1'b0 || dram_addr !== '0) begin
            errors++;
            $display("FAIL midreset_we: we=%b addr=%0d, required 0/0", dram_write_enable, dram_addr);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (dram[20] !== 32'hDEADBEEF || wlog.size() !== 0) begin
            errors++;
            $display("FAIL midreset_dram: dram=%h writes=%0d, required deadbeef/0", dram[20], wlog.size());
        end
        reset_npu = 0;
        #1;
        checks++;
        if (get_instr !== 1'b1 || get_instr_addr !== '0) begin
            errors++;
            $display("FAIL midreset_restart: get_instr=%b addr=%0d, required 1/0", get_instr, get_instr_addr);
        end
        run_halt(200, "midreset");
    endtask

    task automatic test_random();
        logic [IW-1:0] prog[$];
        logic [DW-1:0] v;
        bit h;
        int sel, op, bad, n;
        for (int i = 0; i < 1024; i++) begin
            v = $urandom;
            dram[i] <= v;
            m_dram[i] = v;
        end
        for (int id = 0; id < 3; id++)
            for (int a = 0; a < 16; a++) prog.push_back(enc(VRD, id, a, $urandom_range(0, 1023), 0, 0));
        for (int t = 0; t < 16; t++)
            for (int r = 0; r < 4; r++) prog.push_back(enc(MRD, r, t, $urandom_range(0, 1023), 0, 0));
        for (int k = 0; k < 60; k++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0: op = VRD; 1: op = VWR; 2: op = MRD; 3, 4: op = MVMUL;
                5, 6: op = VVADD; 7: op = 6; 8: op = 9; default: op = 15;
            endcase
            prog.push_back(enc(op, $urandom_range(0, 3), $urandom_range(0, 1023), $urandom_range(0, 1023),
                               $urandom_range(0, 3),
                               (op == VWR) ? $urandom_range(512, 1023) : $urandom_range(0, 1023)));
        end
        for (int id = 0; id < 3; id++)
            for (int a = 0; a < 16; a++) prog.push_back(enc(VWR, id, a, 0, 0, 900 + id*16 + a));
        prog.push_back(enc(ENDC, 0, 0, 0, 0, 0));

        clear_imem();
        for (int k = 0; k < prog.size(); k++) imem[k] <= prog[k];
        exp_q.delete();
        for (int k = 0; k < prog.size(); k++) begin
            model_exec(prog[k], h);
            if (h) break;
        end

        do_reset();
        run_halt(1500, "random");
        checks++;
        if (wlog.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL rand_nwrites: got %0d, required %0d", wlog.size(), exp_q.size());
        end
        n = (wlog.size() < exp_q.size()) ? wlog.size() : exp_q.size();
        for (int k = 0; k < n; k++) begin
            checks++;
            if (wlog[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL rand_write[%0d]: got addr %0d data %h, required addr %0d data %h",
                         k, wlog[k][41:32], wlog[k][31:0], exp_q[k][41:32], exp_q[k][31:0]);
            end
        end
        bad = 0;
        for (int i = 0; i < 1024; i++) if (dram[i] !== m_dram[i]) bad++;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL rand_dram: %0d words differ, required 0", bad);
        end
    endtask

    initial begin
        reset_npu = 1;
        test_reset();
        test_fetch_wrap();
        test_vrd_vwr();
        test_mvmul();
        test_vvadd();
        test_halt();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
